// File: rtl/hazard_ctrl.sv
// ---------------------------------------------------------------------------
// hazard_ctrl -- pipeline hazard and stall controller for the five-stage CPU.
//
// Drives the enable, flush and bubble controls of PC, IF/ID, ID/EX and the
// EX/MEM-onward registers. It resolves load-use hazards, taken-branch flushes
// and multi-cycle data-memory waits. It traps on a memory timeout and keeps a
// saturating count of stall cycles.
//
// Handshake: data memory completes an access in the cycle where
// mem_req_mem=1 and mem_ready=1. While mem_req_mem=1 and mem_ready=0 the
// whole pipe is frozen. mem_ready is ignored when mem_req_mem=0.
//
// Ports:
//   clk, reset         clock; synchronous active-high reset
//   Rn_id, Rm_id       source registers of the instruction in ID
//   use_rm_id          the ID instruction reads Rm_id
//   MemtoReg_ex        the EX instruction is a load
//   RegWrite_ex        the EX instruction writes Rd_ex
//   Rd_ex              destination register of the EX instruction
//   br_taken_ex        a branch resolved taken in EX
//   mem_req_mem        the MEM instruction accesses data memory
//   mem_ready          data memory completes the access this cycle
//   pc_en, if_id_en    load enables for PC and IF/ID
//   if_id_flush        IF/ID loads a NOP
//   id_ex_bubble       ID/EX loads a NOP
//   ex_mem_en          load enable for EX/MEM, MEM/WB and the ID/EX hold
//   mem_timeout        sticky trap flag
//   stall_cnt          saturating count of cycles with pc_en=0
//   state_dbg          FSM state (0=RUN, 1=MEM_WAIT, 2=ERR)
// ---------------------------------------------------------------------------
module hazard_ctrl #(
    parameter int unsigned MAX_MEM_WAIT = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  Rn_id,
    input  logic [4:0]  Rm_id,
    input  logic        use_rm_id,
    input  logic        MemtoReg_ex,
    input  logic        RegWrite_ex,
    input  logic [4:0]  Rd_ex,
    input  logic        br_taken_ex,
    input  logic        mem_req_mem,
    input  logic        mem_ready,
    output logic        pc_en,
    output logic        if_id_en,
    output logic        if_id_flush,
    output logic        id_ex_bubble,
    output logic        ex_mem_en,
    output logic        mem_timeout,
    output logic [31:0] stall_cnt,
    output logic [1:0]  state_dbg
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERR      = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  wait_q, wait_d;
    logic [31:0] stall_q;
    logic        freeze;
    logic        lu;

    assign freeze = mem_req_mem & ~mem_ready;

    // X31 reads as zero, so a load targeting it never creates a dependency.
    assign lu = MemtoReg_ex & RegWrite_ex & (Rd_ex != 5'd31) &
                ((Rd_ex == Rn_id) | (use_rm_id & (Rd_ex == Rm_id)));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= RUN;
            wait_q  <= 8'd0;
            stall_q <= 32'd0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            if (!pc_en && (stall_q != 32'hFFFF_FFFF)) begin
                stall_q <= stall_q + 32'd1;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        wait_d       = wait_q;
        pc_en        = 1'b1;
        if_id_en     = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_bubble = 1'b0;
        ex_mem_en    = 1'b1;

        if (reset) begin
            pc_en        = 1'b0;
            if_id_en     = 1'b0;
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
            ex_mem_en    = 1'b0;
        end else if (state_q == ERR) begin
            pc_en     = 1'b0;
            if_id_en  = 1'b0;
            ex_mem_en = 1'b0;
        end else if (freeze) begin
            pc_en     = 1'b0;
            if_id_en  = 1'b0;
            ex_mem_en = 1'b0;
            // Count this frozen cycle; a RUN entry is always the first one.
            wait_d  = (state_q == RUN) ? 8'd1 : wait_q + 8'd1;
            state_d = (wait_d == 8'(MAX_MEM_WAIT)) ? ERR : MEM_WAIT;
        end else begin
            // Release (or normal) cycle: ordinary hazard priorities apply.
            wait_d  = 8'd0;
            state_d = RUN;
            if (br_taken_ex) begin
                // The flush squashes IF/ID, so its enable is left at 1.
                if_id_flush  = 1'b1;
                id_ex_bubble = 1'b1;
            end else if (lu) begin
                pc_en        = 1'b0;
                if_id_en     = 1'b0;
                id_ex_bubble = 1'b1;
            end
        end
    end

    assign mem_timeout = (state_q == ERR) & ~reset;
    assign stall_cnt   = stall_q;
    assign state_dbg   = state_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_hazard_ctrl -- self-checking bench for hazard_ctrl.
// Directed steps and a randomized phase, checked against a reference model
// that tracks the frozen-cycle run length, the trap flag and the stall count.
// ---------------------------------------------------------------------------
module tb_hazard_ctrl;

    localparam int unsigned MAX_WAIT = 15;

    logic        clk;
    logic        reset;
    logic [4:0]  Rn_id, Rm_id, Rd_ex;
    logic        use_rm_id, MemtoReg_ex, RegWrite_ex, br_taken_ex;
    logic        mem_req_mem, mem_ready;
    logic        pc_en, if_id_en, if_id_flush, id_ex_bubble, ex_mem_en;
    logic        mem_timeout;
    logic [31:0] stall_cnt;
    logic [1:0]  state_dbg;

    int          n_checks;
    int          n_errors;

    // Reference model state
    int          m_run;    // consecutive frozen cycles so far
    bit          m_err;
    logic [31:0] m_stall;

    hazard_ctrl #(.MAX_MEM_WAIT(MAX_WAIT)) dut (
        .clk          (clk),
        .reset        (reset),
        .Rn_id        (Rn_id),
        .Rm_id        (Rm_id),
        .use_rm_id    (use_rm_id),
        .MemtoReg_ex  (MemtoReg_ex),
        .RegWrite_ex  (RegWrite_ex),
        .Rd_ex        (Rd_ex),
        .br_taken_ex  (br_taken_ex),
        .mem_req_mem  (mem_req_mem),
        .mem_ready    (mem_ready),
        .pc_en        (pc_en),
        .if_id_en     (if_id_en),
        .if_id_flush  (if_id_flush),
        .id_ex_bubble (id_ex_bubble),
        .ex_mem_en    (ex_mem_en),
        .mem_timeout  (mem_timeout),
        .stall_cnt    (stall_cnt),
        .state_dbg    (state_dbg)
    );

    // ---------------- clock ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- checking ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic idle_inputs();
        reset       = 1'b0;
        Rn_id       = 5'd1;
        Rm_id       = 5'd2;
        use_rm_id   = 1'b1;
        MemtoReg_ex = 1'b0;
        RegWrite_ex = 1'b0;
        Rd_ex       = 5'd7;
        br_taken_ex = 1'b0;
        mem_req_mem = 1'b0;
        mem_ready   = 1'b1;
    endtask

    task automatic set_load(input logic [4:0] rd, input logic [4:0] rn,
                            input logic [4:0] rm, input logic use_rm);
        MemtoReg_ex = 1'b1;
        RegWrite_ex = 1'b1;
        Rd_ex       = rd;
        Rn_id       = rn;
        Rm_id       = rm;
        use_rm_id   = use_rm;
    endtask

    // Called at a negedge with inputs already driven: check outputs against
    // the model, then advance the model across the next rising edge.
    task automatic step(input string tag);
        bit frz, dep, e_pc, e_ifid, e_flush, e_bub, e_exm, ifid_care;
        int e_state;
        #1;
        frz = mem_req_mem && !mem_ready;
        dep = MemtoReg_ex && RegWrite_ex && (Rd_ex != 5'd31) &&
              ((Rd_ex == Rn_id) || (use_rm_id && (Rd_ex == Rm_id)));
        ifid_care = 1'b1;
        if (reset) begin
            {e_pc, e_ifid, e_flush, e_bub, e_exm} = 5'b00110;
        end else if (m_err || frz) begin
            {e_pc, e_ifid, e_flush, e_bub, e_exm} = 5'b00000;
        end else if (br_taken_ex) begin
            {e_pc, e_ifid, e_flush, e_bub, e_exm} = 5'b10111;
            ifid_care = 1'b0;
        end else if (dep) begin
            {e_pc, e_ifid, e_flush, e_bub, e_exm} = 5'b00011;
        end else begin
            {e_pc, e_ifid, e_flush, e_bub, e_exm} = 5'b11001;
        end
        e_state = m_err ? 2 : ((m_run > 0) ? 1 : 0);

        chk({tag, ".pc_en"},        32'(pc_en),        32'(e_pc));
        if (ifid_care) chk({tag, ".if_id_en"}, 32'(if_id_en), 32'(e_ifid));
        chk({tag, ".if_id_flush"},  32'(if_id_flush),  32'(e_flush));
        chk({tag, ".id_ex_bubble"}, 32'(id_ex_bubble), 32'(e_bub));
        chk({tag, ".ex_mem_en"},    32'(ex_mem_en),    32'(e_exm));
        chk({tag, ".mem_timeout"},  32'(mem_timeout),  32'(m_err && !reset));
        chk({tag, ".stall_cnt"},    stall_cnt,         m_stall);
        chk({tag, ".state"},        32'(state_dbg),    32'(e_state));

        @(posedge clk);
        if (reset) begin
            m_err   = 1'b0;
            m_run   = 0;
            m_stall = 32'd0;
        end else begin
            if (!e_pc && (m_stall != 32'hFFFF_FFFF)) m_stall = m_stall + 32'd1;
            if (!m_err) begin
                if (frz) begin
                    m_run++;
                    if (m_run >= int'(MAX_WAIT)) m_err = 1'b1;
                end else begin
                    m_run = 0;
                end
            end
        end
        @(negedge clk);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [4:0] regs [4];
        n_checks = 0;
        n_errors = 0;
        m_run    = 0;
        m_err    = 1'b0;
        m_stall  = 32'd0;
        regs[0] = 5'd3; regs[1] = 5'd5; regs[2] = 5'd31; regs[3] = 5'd9;

        idle_inputs();
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        step("reset0");
        step("reset1");
        reset = 1'b0;
        step("idle");

        // Load-use on Rn
        set_load(5'd3, 5'd3, 5'd0, 1'b1);
        step("lu_rn");
        idle_inputs();
        step("lu_rn_after");
        chk("lu_stall_cnt", stall_cnt, 32'd1);

        // XZR never causes a stall
        set_load(5'd31, 5'd31, 5'd31, 1'b1);
        step("lu_xzr");
        // Rm match ignored when Rm not read
        set_load(5'd4, 5'd1, 5'd4, 1'b0);
        step("lu_rm_unused");
        // Rm match when Rm is read
        set_load(5'd4, 5'd1, 5'd4, 1'b1);
        step("lu_rm_used");
        idle_inputs();
        step("idle2");

        // Taken branch, then branch with coincident load-use
        br_taken_ex = 1'b1;
        step("branch");
        set_load(5'd6, 5'd6, 5'd0, 1'b1);
        step("branch_lu");
        idle_inputs();
        step("idle3");

        // Memory wait of 4 cycles, released on the 5th
        mem_req_mem = 1'b1;
        mem_ready   = 1'b0;
        for (int i = 0; i < 4; i++) step("memwait");
        mem_ready = 1'b1;
        step("mem_release");
        idle_inputs();
        step("idle4");

        // Timeout: 15 frozen cycles, ERR from cycle 16, stays with ready=1
        mem_req_mem = 1'b1;
        mem_ready   = 1'b0;
        for (int i = 0; i < 15; i++) step("timeout_wait");
        step("timeout_trap");
        chk("timeout_flag", 32'(mem_timeout), 32'd1);
        mem_ready = 1'b1;
        step("err_hold0");
        idle_inputs();
        step("err_hold1");

        // Reset out of ERR
        reset = 1'b1;
        step("err_reset");
        reset = 1'b0;
        step("after_reset");

        // Saturation: preload the counter close to the top
        force dut.stall_q = 32'hFFFF_FFFD;
        #1;
        release dut.stall_q;
        m_stall = 32'hFFFF_FFFD;
        set_load(5'd8, 5'd8, 5'd0, 1'b0);
        for (int i = 0; i < 5; i++) step("saturate");
        chk("sat_hold", stall_cnt, 32'hFFFF_FFFF);
        idle_inputs();
        reset = 1'b1;
        step("sat_reset");
        reset = 1'b0;

        // Randomized phase
        for (int n = 0; n < 600; n++) begin
            reset       = ($urandom_range(0, 59) == 0);
            MemtoReg_ex = $urandom_range(0, 1);
            RegWrite_ex = ($urandom_range(0, 3) != 0);
            Rd_ex       = regs[$urandom_range(0, 3)];
            Rn_id       = regs[$urandom_range(0, 3)];
            Rm_id       = regs[$urandom_range(0, 3)];
            use_rm_id   = $urandom_range(0, 1);
            br_taken_ex = ($urandom_range(0, 4) == 0);
            mem_req_mem = $urandom_range(0, 1);
            mem_ready   = ($urandom_range(0, 3) != 0);
            // Occasionally hold a long freeze so the trap is reached.
            if ((n % 150) >= 130) begin
                mem_req_mem = 1'b1;
                mem_ready   = 1'b0;
                reset       = 1'b0;
            end
            step("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard and stall controller for the five-stage pipelined CPU. It drives the enable, flush and bubble controls of the PC, the IF/ID register, the ID/EX register and the EX/MEM-onward registers. It resolves load-use hazards, taken-branch flushes and multi-cycle data-memory waits, and traps a memory timeout. It also keeps a saturating stall-cycle counter for performance measurement.

## Interface
Parameters:
- MAX_MEM_WAIT, default 15: number of consecutive frozen memory cycles after which the block traps (legal range 1..255).

Ports:
- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  synchronous, active-high
- Rn_id  in  5  first source register of the instruction in ID
- Rm_id  in  5  second source register in ID, after the Reg2Loc mux
- use_rm_id  in  1  the instruction in ID reads Rm_id
- MemtoReg_ex  in  1  the instruction in EX is a load
- RegWrite_ex  in  1  the instruction in EX writes a register
- Rd_ex  in  5  destination register of the instruction in EX
- br_taken_ex  in  1  a branch resolved as taken in EX this cycle
- mem_req_mem  in  1  the instruction in MEM accesses data memory
- mem_ready  in  1  data memory completes the access this cycle
- pc_en  out  1  PC register load enable
- if_id_en  out  1  IF/ID register load enable
- if_id_flush  out  1  IF/ID register loads a NOP
- id_ex_bubble  out  1  ID/EX register loads a NOP (all control bits 0)
- ex_mem_en  out  1  load enable for EX/MEM, MEM/WB and the ID/EX hold
- mem_timeout  out  1  sticky trap flag
- stall_cnt  out  32  count of cycles with pc_en=0

## Operation
- FSM states: RUN, MEM_WAIT, ERR. Reset state: RUN. Reset clears wait_cnt and stall_cnt to 0.
- While reset=1, the outputs are pc_en=if_id_en=ex_mem_en=0, if_id_flush=id_ex_bubble=1 and mem_timeout=0.
- freeze = mem_req_mem & ~mem_ready.
- lu = MemtoReg_ex & RegWrite_ex & (Rd_ex≠31) & ((Rd_ex==Rn_id) | (use_rm_id & Rd_ex==Rm_id)). X31 (XZR) never causes a hazard.
- Output priority in RUN and MEM_WAIT, first match wins:
  1. freeze: all enables 0, flush and bubble 0. The whole pipe holds.
  2. br_taken_ex: pc_en=1, if_id_flush=1, id_ex_bubble=1, ex_mem_en=1. if_id_en is don't-care because flush wins.
  3. lu: pc_en=0, if_id_en=0, id_ex_bubble=1, ex_mem_en=1.
  4. Otherwise: pc_en=if_id_en=ex_mem_en=1, flush and bubble 0.
- Transitions:
  - RUN with freeze: wait_cnt←1. Next state is ERR if MAX_MEM_WAIT==1, otherwise MEM_WAIT.
  - MEM_WAIT with freeze: wait_cnt←wait_cnt+1. If wait_cnt+1==MAX_MEM_WAIT, next state is ERR.
  - MEM_WAIT without freeze: next state RUN, wait_cnt←0. The release cycle itself uses priorities 2–4.
  - ERR: all enables 0, flush and bubble 0, mem_timeout=1. ERR is exited only by reset.
- stall_cnt increments in every non-reset cycle with pc_en=0, including ERR. It saturates at 0xFFFF_FFFF and does not wrap.
- A branch coinciding with a load-use hazard resolves as the branch (priority 2). The dependent instruction in ID is flushed, so no stall occurs.
- Reset asserted in MEM_WAIT or ERR returns the block to RUN on the next edge, with wait_cnt=0, stall_cnt=0 and mem_timeout=0.

## Timing
- Hazard outputs are combinational from the current-cycle inputs and the registered state. There is no added latency.
- A load-use stall lasts exactly 1 cycle. On the next edge the load has moved to MEM, so lu drops.
- A branch flush is a single cycle. The fetched wrong-path instruction and the instruction in ID are both squashed.
- A memory freeze lasts while mem_ready=0 and releases in the same cycle that mem_ready=1.
- The trap occurs after MAX_MEM_WAIT consecutive frozen cycles. With the default of 15, cycles 1–15 freeze, the state is ERR from cycle 16 and mem_timeout=1 from cycle 16.
- stall_cnt and mem_timeout are registered. stall_cnt reflects the previous cycle's pc_en.

## Test plan
- Load-use: EX holds LDUR X3 (MemtoReg_ex=1, RegWrite_ex=1, Rd_ex=3) and ID has Rn_id=3 → one cycle with pc_en=0, if_id_en=0, id_ex_bubble=1. Next cycle all enables are 1 and stall_cnt=1. Repeat with Rd_ex=31 → no stall. Repeat with a match on Rm_id only and use_rm_id=0 → no stall.
- Taken branch: br_taken_ex=1 → if_id_flush=1, id_ex_bubble=1, pc_en=1 for exactly 1 cycle, and stall_cnt unchanged. Repeat with a simultaneous lu condition → identical outputs.
- Memory wait: mem_req_mem=1 with mem_ready=0 for 4 cycles, then 1 → all enables 0 for 4 cycles and state MEM_WAIT. Release in cycle 5, return to RUN, stall_cnt=4.
- Timeout: MAX_MEM_WAIT=15 and mem_ready held at 0 → mem_timeout=1 from cycle 16. Later mem_ready=1 → the block stays in ERR with enables 0.
- Reset mid-operation: assert reset during ERR → next cycle is RUN with mem_timeout=0, stall_cnt=0 and, with no hazards, all enables 1.
- Saturation: force 2^32+3 stall cycles (or preload through the bench) → stall_cnt holds at 0xFFFF_FFFF.
